// File: rtl/encoder_pending.sv
// Sequential 4-to-2 encoder: sticky pending register drained highest index first
// through a valid/ready output register, with served-event counter and overflow flag.
module encoder_pending #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic [3:0]       Din,
    input  logic             Rdy,
    output logic [1:0]       Do,
    output logic             Vld,
    output logic [3:0]       Pend,
    output logic             Ovf,
    output logic [CNT_W-1:0] Cnt
);

    localparam int unsigned REQ_W  = 4;
    localparam int unsigned CODE_W = 2;

    logic              load;
    logic              xfer;
    logic [CODE_W-1:0] code;
    logic [REQ_W-1:0]  clr;
    logic [REQ_W-1:0]  din_m;
    logic [REQ_W-1:0]  pend_nxt;
    logic              ovf_hit;

    // Priority pick, clear mask and pending/overflow next-state
    always_comb begin
        code = 2'b00;
        if (Pend[3])      code = 2'b11;
        else if (Pend[2]) code = 2'b10;
        else if (Pend[1]) code = 2'b01;

        load  = (!Vld || Rdy) && (Pend != 4'b0000);
        xfer  = Vld && Rdy;
        clr   = load ? (REQ_W'(1) << code) : 4'b0000;
        din_m = En ? Din : 4'b0000;

        // A set on the bit being cleared wins and is not a collision
        pend_nxt = (Pend & ~clr) | din_m;
        ovf_hit  = |(din_m & Pend & ~clr);
    end

    // Output register, pending register, flags and counter
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Pend <= 4'b0000;
            Do   <= 2'b00;
            Vld  <= 1'b0;
            Ovf  <= 1'b0;
            Cnt  <= '0;
        end else begin
            Pend <= pend_nxt;
            if (load) begin
                Do  <= code;
                Vld <= 1'b1;
            end else if (xfer) begin
                Vld <= 1'b0;
            end
            if (ovf_hit) Ovf <= 1'b1;
            if (xfer)    Cnt <= Cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/encoder_pending.md
# encoder_pending

Sequential 4-to-2 encoder, the inverse of the team's 2-to-4 one-hot decoder. It captures 4 request lines into a sticky pending register. It then drains them one at a time, highest index first, as 2-bit codes through a valid/ready output register. It sits wherever decoded one-hot events must be turned back into a binary index for a downstream consumer that can stall.

## Interface
- CNT_W, default 8: width of the served-event counter Cnt.

- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-high reset.
- En  input  1  capture enable; when 0, Din is ignored.
- Din  input  4  request lines, one per code; any number may be high together.
- Rdy  input  1  consumer ready.
- Do  output  2  encoded index of the request being offered.
- Vld  output  1  Do holds a valid code.
- Pend  output  4  pending-request register, direct register output.
- Ovf  output  1  sticky flag: a request arrived on a line already pending.
- Cnt  output  CNT_W  number of completed transfers, modulo 2^CNT_W.

## Operation
- Reset values: Pend=4'b0000, Do=2'b00, Vld=0, Ovf=0, Cnt=0.
- Transfer: a transfer occurs at a rising edge where Vld=1 and Rdy=1.
- Load condition:
  - The output register loads when (Vld=0 or Rdy=1) and Pend != 0.
  - The loaded code is the highest set index of the current Pend register: bit 3 gives 2'b11, bit 0 gives 2'b00.
  - After a load, Vld=1.
- Drain without reload: if Vld=1, Rdy=1 and Pend=0, then Vld goes to 0 and Do holds its last value.
- Clear mask: clr is the one-hot of the loaded bit, or 0 when there is no load.
- Pending update, every edge: Pend <= (Pend & ~clr) | (En ? Din : 4'b0000).
- Same-bit collision: if Din sets the bit that is being cleared, the set wins. The bit stays pending and Ovf is not set.
- Ovf sets when En=1, Din[i]=1, Pend[i]=1 and clr[i]=0 for any i. Ovf clears only on Rst. The duplicate request is merged, not queued.
- Cnt increments by 1 on every transfer and wraps from 2^CNT_W-1 to 0.
- Stall: while Vld=1 and Rdy=0, Do and Vld hold, and Pend keeps accumulating new requests.
- Fixed priority: a continuously re-asserted high bit may starve lower bits. This is accepted behaviour.
- Din is used only through Pend; same-cycle Din never drives Do directly.
- Asynchronous Rst at any time forces all reset values immediately, including mid-stall. Pending requests are discarded.

## Timing
- Request latency:
  - Din sampled at edge t sets Pend after t.
  - The earliest Vld/Do is after edge t+1, provided the output register is free or Rdy=1 at t+1.
- Throughput: one code per cycle while Rdy is held at 1 and Pend != 0.
- Pend, Do, Vld, Ovf and Cnt are all registered outputs; there is no combinational path from any input to any output.
- Rdy is sampled only at the rising edge. Rdy may change while Vld=0 with no effect.
- After Rst deasserts, the first capture happens at the next rising edge.

## Test plan
- Reset: assert Rst mid-cycle with Pend=4'b1010 and Vld=1. Pend, Do, Vld, Ovf and Cnt go to 0 immediately, without waiting for a clock edge.
- Single request: En=1, Din=4'b0100 for one cycle, Rdy=1.
  - Pend=4'b0100 after edge 1.
  - Do=2'b10, Vld=1 and Pend=0 after edge 2.
  - Vld=0 and Cnt=1 after edge 3.
- Multiple requests: Din=4'b1011 for one cycle, Rdy=1. Do takes 2'b11, 2'b01, 2'b00 on consecutive cycles, then Vld=0 and Cnt=3.
- Backpressure: Rdy=0 with Do=2'b11 and Vld=1 for 5 cycles.
  - Do and Vld stay stable.
  - Din=4'b0001 arriving during the stall shows in Pend.
  - After Rdy=1, Do=2'b00 follows on the next cycle.
- Overflow and collision:
  - Din=4'b0010 for two consecutive cycles while the output register is stalled: Ovf=1 and stays 1.
  - Separately, re-assert Din bit 3 in the cycle bit 3 is loaded: Pend[3] stays 1 and Ovf stays 0.
- Enable and wrap:
  - En=0 with Din=4'b1111: Pend stays 0.
  - With CNT_W=2, complete 5 transfers: Cnt reads 1.
